// File: rtl/machine_csr_unit_if.sv
// machine_csr_unit_if: core-side CSR access, trap control and status bundle for machine_csr_unit.
interface machine_csr_unit_if;
    logic        csr_en_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rs1_adder_in;
    logic [31:0] rs1_data_in;
    logic [31:0] pc_in;
    logic [31:0] iadder_in;
    logic        set_epc_in;
    logic        set_cause_in;
    logic        mie_clear_in;
    logic        mie_set_in;
    logic        i_or_e_in;
    logic [3:0]  cause_in;
    logic        misaligned_exception_in;
    logic        instret_inc_in;
    logic        eirq_in;
    logic        tirq_in;
    logic        sirq_in;
    logic [31:0] csr_data_out;
    logic        illegal_csr_out;
    logic        mie_out;
    logic        meie_out;
    logic        mtie_out;
    logic        msie_out;
    logic        meip_out;
    logic        mtip_out;
    logic        msip_out;
    logic [31:0] epc_out;
    logic [31:0] trap_address_out;
    modport master (
        output csr_en_in, csr_addr_in, funct3_in, rs1_adder_in, rs1_data_in, pc_in, iadder_in,
               set_epc_in, set_cause_in, mie_clear_in, mie_set_in, i_or_e_in, cause_in,
               misaligned_exception_in, instret_inc_in, eirq_in, tirq_in, sirq_in,
        input  csr_data_out, illegal_csr_out, mie_out, meie_out, mtie_out, msie_out,
               meip_out, mtip_out, msip_out, epc_out, trap_address_out
    );
    modport slave (
        input  csr_en_in, csr_addr_in, funct3_in, rs1_adder_in, rs1_data_in, pc_in, iadder_in,
               set_epc_in, set_cause_in, mie_clear_in, mie_set_in, i_or_e_in, cause_in,
               misaligned_exception_in, instret_inc_in, eirq_in, tirq_in, sirq_in,
        output csr_data_out, illegal_csr_out, mie_out, meie_out, mtie_out, msie_out,
               meip_out, mtip_out, msip_out, epc_out, trap_address_out
    );
endinterface

// File: rtl/machine_csr_unit.sv
// machine_csr_unit: machine-mode CSR file, trap state, and 64-bit cycle/instret counters.
module machine_csr_unit (
    input logic             clk_in,
    input logic             rst_in,
    machine_csr_unit_if.slave bus
);
    logic        mie_r, mpie, meie, mtie, msie, meip, mtip, msip;
    logic [31:0] mtvec, mscratch, mepc, mtval;
    logic        mcause_irq;
    logic [3:0]  mcause_code;
    logic [63:0] mcycle, minstret;
    logic [31:0] src, rdata, wdata;
    logic [1:0]  op;
    logic        valid, wr_intent, illegal, wr;
    logic        we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;
    logic        we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;
    assign op        = bus.funct3_in[1:0];
    assign src       = bus.funct3_in[2] ? {27'b0, bus.rs1_adder_in} : bus.rs1_data_in;
    assign wr_intent = bus.csr_en_in & ((op == 2'b01) | ((op != 2'b00) & (bus.rs1_adder_in != 5'd0)));
    assign illegal   = bus.csr_en_in & (~valid | ((bus.csr_addr_in[11:10] == 2'b11) & wr_intent));
    assign wr        = wr_intent & ~illegal;
    assign wdata     = op == 2'b01 ? src : op == 2'b10 ? rdata | src : rdata & ~src;
    assign we_mstatus  = wr & (bus.csr_addr_in == 12'h300);
    assign we_mie      = wr & (bus.csr_addr_in == 12'h304);
    assign we_mtvec    = wr & (bus.csr_addr_in == 12'h305);
    assign we_mscratch = wr & (bus.csr_addr_in == 12'h340);
    assign we_mepc     = wr & (bus.csr_addr_in == 12'h341);
    assign we_mcause   = wr & (bus.csr_addr_in == 12'h342);
    assign we_mtval    = wr & (bus.csr_addr_in == 12'h343);
    assign we_cyc_lo   = wr & (bus.csr_addr_in == 12'hB00);
    assign we_cyc_hi   = wr & (bus.csr_addr_in == 12'hB80);
    assign we_ins_lo   = wr & (bus.csr_addr_in == 12'hB02);
    assign we_ins_hi   = wr & (bus.csr_addr_in == 12'hB82);
    always_comb begin
        rdata = 32'd0;
        valid = 1'b1;
        case (bus.csr_addr_in)
            12'h300: rdata = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie_r, 3'd0};
            12'h301: rdata = 32'h4000_0100;
            12'h304: rdata = {20'd0, meie, 3'd0, mtie, 3'd0, msie, 3'd0};
            12'h305: rdata = mtvec;
            12'h340: rdata = mscratch;
            12'h341: rdata = mepc;
            12'h342: rdata = {mcause_irq, 27'd0, mcause_code};
            12'h343: rdata = mtval;
            12'h344: rdata = {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0};
            12'hB00, 12'hC00: rdata = mcycle[31:0];
            12'hB80, 12'hC80: rdata = mcycle[63:32];
            12'hB02, 12'hC02: rdata = minstret[31:0];
            12'hB82, 12'hC82: rdata = minstret[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: rdata = 32'd0;
            default: valid = 1'b0;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            {mie_r, mpie, meie, mtie, msie, meip, mtip, msip} <= 8'd0;
            mtvec       <= 32'd0;
            mscratch    <= 32'd0;
            mepc        <= 32'd0;
            mtval       <= 32'd0;
            mcause_irq  <= 1'b0;
            mcause_code <= 4'd0;
            mcycle      <= 64'd0;
            minstret    <= 64'd0;
        end else begin
            {meip, mtip, msip} <= {bus.eirq_in, bus.tirq_in, bus.sirq_in};
            // trap-driven MIE/MPIE changes take precedence over software writes
            if (bus.mie_clear_in) begin
                mpie  <= mie_r;
                mie_r <= 1'b0;
            end else if (bus.mie_set_in) begin
                mie_r <= mpie;
                mpie  <= 1'b1;
            end else if (we_mstatus) begin
                mie_r <= wdata[3];
                mpie  <= wdata[7];
            end
            if (we_mie) {meie, mtie, msie} <= {wdata[11], wdata[7], wdata[3]};
            if (we_mtvec) mtvec <= wdata & 32'hFFFF_FFFD;
            if (we_mscratch) mscratch <= wdata;
            if (bus.set_epc_in) mepc <= bus.pc_in & 32'hFFFF_FFFC;
            else if (we_mepc) mepc <= wdata & 32'hFFFF_FFFC;
            if (bus.set_cause_in) begin
                mcause_irq  <= bus.i_or_e_in;
                mcause_code <= bus.cause_in;
                mtval       <= bus.misaligned_exception_in ? bus.iadder_in : 32'd0;
            end else begin
                if (we_mcause) {mcause_irq, mcause_code} <= {wdata[31], wdata[3:0]};
                if (we_mtval) mtval <= wdata;
            end
            // a written half is replaced outright; the untouched half neither counts nor carries
            mcycle   <= we_cyc_lo ? {mcycle[63:32], wdata} : we_cyc_hi ? {wdata, mcycle[31:0]} : mcycle + 64'd1;
            minstret <= we_ins_lo ? {minstret[63:32], wdata} : we_ins_hi ? {wdata, minstret[31:0]}
                      : minstret + {63'd0, bus.instret_inc_in};
        end
    end
    assign bus.csr_data_out     = rdata;
    assign bus.illegal_csr_out  = illegal;
    assign bus.mie_out          = mie_r;
    assign bus.meie_out         = meie;
    assign bus.mtie_out         = mtie;
    assign bus.msie_out         = msie;
    assign bus.meip_out         = meip;
    assign bus.mtip_out         = mtip;
    assign bus.msip_out         = msip;
    assign bus.epc_out          = mepc;
    assign bus.trap_address_out = {mtvec[31:2], 2'b00}
                                + ((mtvec[0] & mcause_irq) ? {26'd0, mcause_code, 2'b00} : 32'd0);
endmodule

// File: tb/tb_machine_csr_unit.sv
// tb_machine_csr_unit: directed vectors with hand-computed expectations for machine_csr_unit.
module tb_machine_csr_unit;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;
    machine_csr_unit_if bus();
    machine_csr_unit dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus.slave));
    always #5 clk_in = ~clk_in;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    task automatic idle();
        bus.csr_en_in = 0; bus.csr_addr_in = 0; bus.funct3_in = 0; bus.rs1_adder_in = 0;
        bus.rs1_data_in = 0; bus.pc_in = 0; bus.iadder_in = 0; bus.set_epc_in = 0;
        bus.set_cause_in = 0; bus.mie_clear_in = 0; bus.mie_set_in = 0; bus.i_or_e_in = 0;
        bus.cause_in = 0; bus.misaligned_exception_in = 0; bus.instret_inc_in = 0;
    endtask
    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r, input logic [31:0] d);
        bus.csr_en_in = 1; bus.funct3_in = f3; bus.csr_addr_in = a;
        bus.rs1_adder_in = r; bus.rs1_data_in = d;
    endtask
    task automatic csr_rd(input logic [11:0] a);
        csr_op(3'b010, a, 5'd0, 32'd0);
        #1;
    endtask
    function automatic logic [31:0] flags();
        return {25'd0, bus.mie_out, bus.meie_out, bus.mtie_out, bus.msie_out,
                bus.meip_out, bus.mtip_out, bus.msip_out};
    endfunction
    initial begin
        idle();
        bus.eirq_in = 0; bus.tirq_in = 0; bus.sirq_in = 0;
        tick(); tick();
        rst_in = 0;
        csr_rd(12'h301);
        chk("misa", bus.csr_data_out, 32'h4000_0100);
        chk("rst_illegal", {31'd0, bus.illegal_csr_out}, 0);
        chk("rst_epc", bus.epc_out, 0);
        chk("rst_trap", bus.trap_address_out, 0);
        chk("rst_flags", flags(), 0);
        tick(); csr_rd(12'hB00);
        chk("mcycle_start", bus.csr_data_out, 1);
        csr_op(3'b001, 12'h340, 5'd3, 32'hDEAD_BEEF);
        tick(); csr_rd(12'h340);
        chk("mscratch", bus.csr_data_out, 32'hDEAD_BEEF);
        tick(); csr_rd(12'h340);
        chk("mscratch_rs_x0", bus.csr_data_out, 32'hDEAD_BEEF);
        csr_op(3'b001, 12'h305, 5'd3, 32'h0000_1001);
        tick(); csr_rd(12'h305);
        chk("mtvec", bus.csr_data_out, 32'h0000_1001);
        idle(); bus.set_cause_in = 1; bus.i_or_e_in = 1; bus.cause_in = 4'd7;
        tick(); idle(); #1;
        chk("trap_vec_irq", bus.trap_address_out, 32'h0000_101C);
        csr_rd(12'h342);
        chk("mcause_irq", bus.csr_data_out, 32'h8000_0007);
        tick(); csr_rd(12'h343);
        chk("mtval_zero", bus.csr_data_out, 0);
        idle(); bus.set_cause_in = 1; bus.cause_in = 4'd7;
        tick(); idle(); #1;
        chk("trap_vec_exc", bus.trap_address_out, 32'h0000_1000);
        csr_op(3'b110, 12'h300, 5'd8, 32'd0);
        tick(); csr_rd(12'h300);
        chk("mstatus_mie", bus.csr_data_out, 32'h0000_1808);
        chk("mie_out", {31'd0, bus.mie_out}, 1);
        idle(); bus.mie_clear_in = 1;
        tick(); idle(); csr_rd(12'h300);
        chk("mie_clear", bus.csr_data_out, 32'h0000_1880);
        idle(); bus.mie_set_in = 1;
        tick(); idle(); csr_rd(12'h300);
        chk("mie_set", bus.csr_data_out, 32'h0000_1888);
        idle(); bus.mie_set_in = 1; bus.mie_clear_in = 1;
        tick(); idle(); csr_rd(12'h300);
        chk("clear_wins", bus.csr_data_out, 32'h0000_1880);
        csr_op(3'b001, 12'hB00, 5'd3, 32'hFFFF_FFFF);
        tick(); csr_op(3'b001, 12'hB80, 5'd3, 32'd0);
        tick(); csr_rd(12'hB00);
        chk("mcycle_lo_held", bus.csr_data_out, 32'hFFFF_FFFF);
        tick(); csr_rd(12'hC00);
        chk("cycle_wrap", bus.csr_data_out, 0);
        tick(); csr_rd(12'hC80);
        chk("cycleh_carry", bus.csr_data_out, 1);
        csr_op(3'b001, 12'hC00, 5'd3, 32'h55); #1;
        chk("cycle_ro_illegal", {31'd0, bus.illegal_csr_out}, 1);
        tick(); csr_rd(12'hC00);
        chk("cycle_after_illegal", bus.csr_data_out, 2);
        idle(); bus.instret_inc_in = 1;
        tick(); tick(); tick();
        bus.instret_inc_in = 0; csr_rd(12'hB02);
        chk("minstret", bus.csr_data_out, 3);
        csr_op(3'b001, 12'hB02, 5'd3, 32'd10); bus.instret_inc_in = 1;
        tick(); idle(); csr_rd(12'hB02);
        chk("minstret_write", bus.csr_data_out, 10);
        tick(); csr_rd(12'hC82);
        chk("instreth", bus.csr_data_out, 0);
        idle(); csr_op(3'b001, 12'h341, 5'd3, 32'h5555);
        bus.set_epc_in = 1; bus.set_cause_in = 1; bus.pc_in = 32'h103; bus.iadder_in = 32'h2001;
        bus.cause_in = 4'd4; bus.misaligned_exception_in = 1;
        tick(); idle(); csr_rd(12'h341);
        chk("mepc_trap", bus.csr_data_out, 32'h100);
        chk("epc_out", bus.epc_out, 32'h100);
        tick(); csr_rd(12'h343);
        chk("mtval_misaligned", bus.csr_data_out, 32'h2001);
        tick(); csr_rd(12'h342);
        chk("mcause_exc", bus.csr_data_out, 4);
        idle(); bus.eirq_in = 1; bus.tirq_in = 1;
        tick(); #1;
        chk("mip_flags", flags() & 32'h7, 32'h6);
        csr_rd(12'h344);
        chk("mip_read", bus.csr_data_out, 32'h880);
        bus.eirq_in = 0; bus.tirq_in = 0;
        csr_op(3'b001, 12'h304, 5'd3, 32'h888);
        tick(); idle(); #1;
        chk("mie_reg_flags", (flags() >> 3) & 32'h7, 32'h7);
        csr_rd(12'h7C0);
        chk("unimpl_illegal", {31'd0, bus.illegal_csr_out}, 1);
        csr_rd(12'hF14);
        chk("mhartid", bus.csr_data_out, 0);
        chk("mhartid_read_ok", {31'd0, bus.illegal_csr_out}, 0);
        csr_op(3'b010, 12'hF14, 5'd1, 32'd1); #1;
        chk("mhartid_write_illegal", {31'd0, bus.illegal_csr_out}, 1);
        csr_op(3'b001, 12'h301, 5'd3, 32'd0); #1;
        chk("misa_write_legal", {31'd0, bus.illegal_csr_out}, 0);
        tick(); csr_rd(12'h301);
        chk("misa_unchanged", bus.csr_data_out, 32'h4000_0100);
        csr_op(3'b001, 12'h340, 5'd3, 32'h1234); rst_in = 1;
        tick(); rst_in = 0; csr_rd(12'h340);
        chk("reset_discards", bus.csr_data_out, 0);
        chk("reset_trap", bus.trap_address_out, 0);
        chk("reset_flags", flags(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
